// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard tracker: forward-select
// encodings, the per-stage entry record and the producer-matching functions.
package hazard_pkg;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_E     = 2'd1;
  localparam logic [1:0] FWD_M     = 2'd2;
  localparam logic [1:0] FWD_W     = 2'd3;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic       regwrite;
    logic [4:0] wreg;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } stage_entry_t;

  localparam stage_entry_t BUBBLE = '0;

  // Register 0 is hard-wired, so a write to it never produces anything.
  function automatic logic produces(stage_entry_t e, logic [4:0] r);
    return e.regwrite && (e.wreg != 5'd0) && (e.wreg == r);
  endfunction

  function automatic logic ready(stage_entry_t e, logic [4:0] r);
    return produces(e, r) && (e.tnew == 2'd0);
  endfunction

  function automatic logic late(stage_entry_t e, logic [4:0] r, logic [1:0] tuse);
    return (tuse != TUSE_NONE) && produces(e, r) && (e.tnew > tuse);
  endfunction

  // Nearest ready producer wins; pass BUBBLE for stages that cannot feed r.
  function automatic logic [1:0] fwd_sel(stage_entry_t e, stage_entry_t m,
                                         stage_entry_t w, logic [4:0] r);
    if (ready(e, r))      return FWD_E;
    else if (ready(m, r)) return FWD_M;
    else if (ready(w, r)) return FWD_W;
    else                  return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One tracked pipeline entry: loads the upstream entry, optionally replaced
// by a bubble, with the result latency decremented or cleared on the way in.
module hazard_stage_reg
  import hazard_pkg::*;
#(
  parameter bit DEC_TNEW = 1'b0,
  parameter bit CLR_TNEW = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bubble_i,
  input  stage_entry_t d_i,
  output stage_entry_t q_o
);

  stage_entry_t entry_d, entry_q;

  always_comb begin
    // NOTE: full default first, so no path leaves entry_d unassigned (no latch).
    entry_d = d_i;
    if (CLR_TNEW) begin
      entry_d.tnew = 2'd0;
    end else if (DEC_TNEW && (d_i.tnew != 2'd0)) begin
      entry_d.tnew = d_i.tnew - 2'd1;
    end
    if (bubble_i) begin
      entry_d = BUBBLE;
    end
  end

  // NOTE: registered state uses <= so all stages update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q <= BUBBLE;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/hazard_tracker.sv
// Stall/forward controller for a 5-stage MIPS-like pipeline tracking E/M/W.
// Forwarding is built only when HAZARD_TRACKER_FWD_EN is defined.
module hazard_tracker
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic        d_regwrite,
  input  logic [4:0]  d_wreg,
  input  logic [1:0]  d_tnew,
  output logic        stall,
  output logic [1:0]  fwd_rs_d,
  output logic [1:0]  fwd_rt_d,
  output logic [1:0]  fwd_rs_e,
  output logic [1:0]  fwd_rt_e,
  output logic [1:0]  fwd_rt_m,
  output logic [31:0] stall_cnt
);

  stage_entry_t d_entry, e_q, m_q, w_q;
  logic [31:0]  stall_cnt_q;
  logic         unused_bits;

  assign d_entry = '{regwrite: d_regwrite, wreg: d_wreg, tnew: d_tnew,
                     rs: d_rs, rt: d_rt};

  hazard_stage_reg #(.DEC_TNEW(1'b0), .CLR_TNEW(1'b0)) u_stage_e (
    .clk(clk), .reset(reset), .bubble_i(stall), .d_i(d_entry), .q_o(e_q)
  );

  hazard_stage_reg #(.DEC_TNEW(1'b1), .CLR_TNEW(1'b0)) u_stage_m (
    .clk(clk), .reset(reset), .bubble_i(1'b0), .d_i(e_q), .q_o(m_q)
  );

  hazard_stage_reg #(.DEC_TNEW(1'b0), .CLR_TNEW(1'b1)) u_stage_w (
    .clk(clk), .reset(reset), .bubble_i(1'b0), .d_i(m_q), .q_o(w_q)
  );

  always_comb begin
    stall    = 1'b0;
    fwd_rs_d = FWD_RF;
    fwd_rt_d = FWD_RF;
    fwd_rs_e = FWD_RF;
    fwd_rt_e = FWD_RF;
    fwd_rt_m = FWD_RF;
`ifdef HAZARD_TRACKER_FWD_EN
    // W results are always forwardable, so only E and M can be too late.
    stall = late(e_q, d_rs, d_tuse_rs) || late(m_q, d_rs, d_tuse_rs) ||
            late(e_q, d_rt, d_tuse_rt) || late(m_q, d_rt, d_tuse_rt);
    fwd_rs_d = fwd_sel(e_q, m_q, w_q, d_rs);
    fwd_rt_d = fwd_sel(e_q, m_q, w_q, d_rt);
    fwd_rs_e = fwd_sel(BUBBLE, m_q, w_q, e_q.rs);
    fwd_rt_e = fwd_sel(BUBBLE, m_q, w_q, e_q.rt);
    fwd_rt_m = fwd_sel(BUBBLE, BUBBLE, w_q, m_q.rt);
`else
    // Without bypass paths, any in-flight writer of a read operand blocks D.
    stall = ((d_tuse_rs != TUSE_NONE) &&
             (produces(e_q, d_rs) || produces(m_q, d_rs) || produces(w_q, d_rs))) ||
            ((d_tuse_rt != TUSE_NONE) &&
             (produces(e_q, d_rt) || produces(m_q, d_rt) || produces(w_q, d_rt)));
`endif
  end

  assign unused_bits = ^{e_q.rs, e_q.rt, e_q.tnew, m_q.rs, m_q.rt, m_q.tnew,
                         w_q.rs, w_q.rt, w_q.tnew};

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker; expectations adapt to HAZARD_TRACKER_FWD_EN.
module tb_hazard_tracker;

  logic        clk;
  logic        reset;
  logic [4:0]  d_rs, d_rt, d_wreg;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic        d_regwrite;
  logic        stall;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;
  logic [31:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_tracker dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_regwrite(d_regwrite), .d_wreg(d_wreg), .d_tnew(d_tnew),
    .stall(stall),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input int rs, input int rt, input int tu_rs, input int tu_rt,
                       input int rw, input int wr, input int tn);
    d_rs       = 5'(rs);
    d_rt       = 5'(rt);
    d_tuse_rs  = 2'(tu_rs);
    d_tuse_rt  = 2'(tu_rt);
    d_regwrite = 1'(rw);
    d_wreg     = 5'(wr);
    d_tnew     = 2'(tn);
    #1;
  endtask

  task automatic set_idle();
    set_d(0, 0, 3, 3, 0, 0, 0);
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] fwd_all();
    return 32'({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m});
  endfunction

  initial begin
    reset = 1'b1;
    set_idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_cnt", stall_cnt, 32'd0);
    chk("reset_fwd", fwd_all(), 32'd0);

`ifdef HAZARD_TRACKER_FWD_EN
    // lw $2 then addu $2: one stall, then W->E forward
    do_reset();
    set_d(29, 0, 1, 3, 1, 2, 2);
    chk("lw_addu_first", 32'(stall), 32'd0);
    tick();
    set_d(2, 7, 1, 1, 1, 4, 1);
    chk("lw_addu_stall", 32'(stall), 32'd1);
    tick();
    chk("lw_addu_release", 32'(stall), 32'd0);
    chk("lw_addu_no_dfwd", 32'(fwd_rs_d), 32'd0);
    tick();
    set_idle();
    chk("lw_addu_fwd_rs_e", 32'(fwd_rs_e), 32'd3);
    chk("lw_addu_cnt", stall_cnt, 32'd1);

    // lw $2 then beq $2: two stalls, then W->D forward
    do_reset();
    set_d(29, 0, 1, 3, 1, 2, 2);
    tick();
    set_d(2, 0, 0, 0, 0, 0, 0);
    chk("lw_beq_stall1", 32'(stall), 32'd1);
    tick();
    chk("lw_beq_stall2", 32'(stall), 32'd1);
    tick();
    chk("lw_beq_release", 32'(stall), 32'd0);
    chk("lw_beq_fwd_rs_d", 32'(fwd_rs_d), 32'd3);
    chk("lw_beq_cnt", stall_cnt, 32'd2);

    // jal then jr $31: E->D forward, no stall
    do_reset();
    set_d(0, 0, 3, 3, 1, 31, 0);
    tick();
    set_d(31, 0, 0, 3, 0, 0, 0);
    chk("jal_jr_stall", 32'(stall), 32'd0);
    chk("jal_jr_fwd_rs_d", 32'(fwd_rs_d), 32'd1);

    // addu $3 then subu $3,$3: no stall, M->E forward on both operands
    do_reset();
    set_d(1, 2, 1, 1, 1, 3, 1);
    tick();
    set_d(3, 3, 1, 1, 1, 5, 1);
    chk("addu_subu_stall", 32'(stall), 32'd0);
    chk("addu_subu_no_dfwd", 32'(fwd_rs_d), 32'd0);
    tick();
    set_idle();
    chk("addu_subu_fwd_rs_e", 32'(fwd_rs_e), 32'd2);
    chk("addu_subu_fwd_rt_e", 32'(fwd_rt_e), 32'd2);

    // ori $0 then reader of $0: never forwards or stalls
    do_reset();
    set_d(0, 0, 3, 3, 1, 0, 1);
    tick();
    set_d(0, 0, 0, 0, 0, 0, 0);
    chk("zero_reg_stall", 32'(stall), 32'd0);
    chk("zero_reg_fwd_d", fwd_all(), 32'd0);
    tick();
    chk("zero_reg_fwd_e", fwd_all(), 32'd0);

    // addu $6 then sw $6: store data forwarded M->E, then W->M
    do_reset();
    set_d(1, 2, 1, 1, 1, 6, 1);
    tick();
    set_d(0, 6, 1, 2, 0, 0, 0);
    chk("sw_stall", 32'(stall), 32'd0);
    tick();
    set_idle();
    chk("sw_fwd_rt_e", 32'(fwd_rt_e), 32'd2);
    tick();
    chk("sw_fwd_rt_m", 32'(fwd_rt_m), 32'd3);
`else
    // addu $3 then subu $3: producer blocks D through E, M and W
    do_reset();
    set_d(1, 2, 1, 1, 1, 3, 1);
    chk("nf_addu_stall", 32'(stall), 32'd0);
    tick();
    set_d(3, 4, 1, 1, 1, 5, 1);
    chk("nf_subu_stall_e", 32'(stall), 32'd1);
    chk("nf_subu_fwd", fwd_all(), 32'd0);
    tick();
    chk("nf_subu_stall_m", 32'(stall), 32'd1);
    tick();
    chk("nf_subu_stall_w", 32'(stall), 32'd1);
    chk("nf_subu_fwd_w", fwd_all(), 32'd0);
    tick();
    chk("nf_subu_release", 32'(stall), 32'd0);
    chk("nf_subu_cnt", stall_cnt, 32'd3);
    tick();

    // subu $5 in E; operands of $5 marked unused must not stall
    set_d(5, 5, 3, 3, 1, 0, 1);
    chk("nf_tuse_none", 32'(stall), 32'd0);
    tick();

    // ori $0 in E; reader of $0 must not stall
    set_d(0, 0, 0, 0, 0, 0, 0);
    chk("nf_zero_reg", 32'(stall), 32'd0);
    tick();

    // subu $5 now in W; rt read of $5 still stalls without bypass
    set_d(0, 5, 0, 2, 0, 0, 0);
    chk("nf_w_stall", 32'(stall), 32'd1);
    tick();
    chk("nf_w_release", 32'(stall), 32'd0);
    chk("nf_w_cnt", stall_cnt, 32'd4);
`endif

    // reset in the middle of a lw/beq stall drops the stall and the count
    do_reset();
    set_d(29, 0, 1, 3, 1, 2, 2);
    chk("rst_lw_stall", 32'(stall), 32'd0);
    tick();
    set_d(2, 0, 0, 0, 0, 0, 0);
    chk("rst_beq_stall1", 32'(stall), 32'd1);
    tick();
    chk("rst_beq_stall2", 32'(stall), 32'd1);
    chk("rst_beq_cnt", stall_cnt, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_after_stall", 32'(stall), 32'd0);
    chk("rst_after_cnt", stall_cnt, 32'd0);
    chk("rst_after_fwd", fwd_all(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 SHALL have clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have reset  input  1  synchronous, active-high; clears all state on the next clk edge.
REQ-003 SHALL have d_rs, d_rt  input  5 each  source register numbers of the instruction in D.
REQ-004 SHALL have d_tuse_rs, d_tuse_rt  input  2 each  cycles until operand needed (0..2); 3 = operand not read.
REQ-005 SHALL have d_regwrite  input  1, d_wreg  input  5, d_tnew  input  2  D-instruction write enable, destination, result latency measured from E.
REQ-006 SHALL have stall  output  1  freeze PC and IF/ID register this cycle.
REQ-007 SHALL have fwd_rs_d, fwd_rt_d  output  2 each  D-operand source select: 0 RF, 1 E, 2 M, 3 W.
REQ-008 SHALL have fwd_rs_e, fwd_rt_e  output  2 each  E-operand select: 0 pipe, 2 M, 3 W.
REQ-009 SHALL have fwd_rt_m  output  2  M store-data select: 0 pipe, 3 W.
REQ-010 SHALL have stall_cnt  output  32  count of stalled cycles.

Function
REQ-011 SHALL track three entries E, M, W, each holding regwrite, wreg, tnew; E additionally rs, rt; M additionally rt.
REQ-012 SHALL treat any entry with wreg==0 or regwrite==0 as no producer; register 0 never stalls or forwards.
REQ-013 SHALL compute stall combinationally: for each D operand with tuse!=3, stall if E or M producer matches it and its tnew > tuse.
REQ-014 SHALL, on clk without stall: E<=D fields, M<=E with tnew decremented saturating at 0, W<=M with tnew=0.
REQ-015 SHALL, on clk with stall: E<=bubble (regwrite=0, wreg=0, rs=rt=0), M<=E, W<=M; D fields not captured.
REQ-016 SHALL forward only from a producer with tnew==0 and matching nonzero wreg; nearest stage wins (E over M over W).
REQ-017 SHALL drive all fwd_* combinationally in the same cycle as the state they reflect; select 0 when no eligible producer.
REQ-018 SHALL increment stall_cnt by 1 on each clk edge where stall==1, saturating at 32'hFFFF_FFFF.
REQ-019 SHALL let a D operand with tuse==3 never cause a stall even when a producer matches.

Reset
REQ-020 SHALL on reset clear all entries to bubble, stall_cnt to 0; outputs stall=0 and all fwd_*=0 in the cycle after reset is sampled.
REQ-021 SHALL give reset priority over stall and normal advance; a stall in progress is dropped.

Configuration
REQ-022 SHALL compile forwarding in only when macro HAZARD_TRACKER_FWD_EN is defined.
REQ-023 SHALL, with HAZARD_TRACKER_FWD_EN: behave per REQ-013..REQ-017.
REQ-024 SHALL, without HAZARD_TRACKER_FWD_EN: tie all fwd_* to 0; stall whenever any E, M or W producer matches a read operand (tuse!=3), ignoring tnew.

Structure
REQ-025 SHALL place forward-select encodings (FWD_RF/FWD_E/FWD_M/FWD_W), TUSE_NONE=3 and the stage-entry typedef in shared package hazard_pkg.
REQ-026 SHALL implement each tracked entry via sub-module hazard_stage_reg (load/bubble/tnew-decrement), instantiated three times.

Verification
REQ-027 lw $2 (tnew 2) then addu reading $2 (tuse 1) -> stall 1 cycle, then fwd_rs_e=3 when addu in E, stall_cnt=1.
REQ-028 lw $2 then beq $2 (tuse 0) -> stall 2 cycles, then fwd_rs_d=3, stall_cnt=2.
REQ-029 jal (wreg 31, tnew 0) then jr $31 (tuse 0) -> no stall, fwd_rs_d=1.
REQ-030 addu $3 (tnew 1) then subu reading $3 -> no stall, next cycle fwd_rs_e=2; ori writing $0 then reader of $0 -> all fwd_*=0, stall=0.
REQ-031 reset asserted during stall of REQ-028 -> next cycle stall=0, stall_cnt=0, all fwd_*=0.
REQ-032 without HAZARD_TRACKER_FWD_EN, addu $3 then subu reading $3 -> stall 3 cycles, all fwd_*=0.
